// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start + DATA_WIDTH data bits (LSB first)
// + optional even parity + one stop bit. Every bit lasts exactly DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit.
//
// Handshake (valid/ready): a byte is transferred on a rising clk edge where
// i_valid && o_ready are both 1. i_data is only looked at on that edge.
// i_valid may be withdrawn at any time without a transfer. o_ready stays
// low for the whole frame; there is no buffering, so upstream must stall.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV        = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_txd,
    output logic                  o_busy,
    output logic [2:0]            o_dbg_state
);

    localparam int TW = $clog2(DIV);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(DIV - 1);
    localparam logic [IW-1:0] LAST_BIT     = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  timer_done;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    assign timer_done = (timer_q == '0);

    // Next-state, bit timer, shifter and registered line/status outputs.
    // txd/ready/busy are computed one cycle early so the pins come from flops.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                txd_d     = 1'b1;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                timer_d   = '0;
                bit_idx_d = '0;
                if (i_valid && ready_q) begin
                    state_d  = S_START;
                    timer_d  = TIMER_RELOAD;
                    shift_d  = i_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^i_data;
`endif
                    txd_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (timer_done) begin
                    state_d   = S_DATA;
                    timer_d   = TIMER_RELOAD;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_done) begin
                    timer_d = TIMER_RELOAD;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        // Next bit is shift_q[1]; move it down for the following bit.
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 1'b1;
                        txd_d     = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_done) begin
                    state_d = S_STOP;
                    timer_d = TIMER_RELOAD;
                    txd_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (timer_done) begin
                    // Back to IDLE: one idle-high cycle before the next start bit.
                    state_d = S_IDLE;
                    timer_d = '0;
                    txd_d   = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                // Illegal encoding: recover to a quiet idle line.
                state_d   = S_IDLE;
                timer_d   = '0;
                bit_idx_d = '0;
                txd_d     = 1'b1;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_txd       = txd_q;
    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with DIV=4, DATA_WIDTH=8.
module tb_uart_tx;

    localparam int DW  = 8;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = DW + 3;
`else
    localparam int FB = DW + 2;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          o_txd;
    logic          o_busy;
    logic [2:0]    o_dbg_state;

    int tests_run;
    int tests_failed;

    uart_tx #(.DATA_WIDTH(DW), .DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_txd       (o_txd),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // Clock: 10 ns period. Inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit position idx of a frame carrying d.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Sends d starting at a negedge with the DUT idle, checks every cycle of
    // the frame, and returns at the negedge of the trailing idle cycle.
    task automatic run_frame(input string name, input logic [DW-1:0] d,
                             input logic [DW-1:0] data_after, input logic hold_valid);
        logic e;
        i_data  = d;
        i_valid = 1'b1;
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_before: got %b want 1", name, o_ready);
        end
        @(negedge clk);
        i_data  = data_after;
        i_valid = hold_valid;
        for (int b = 0; b < FB; b++) begin
            e = exp_bit(d, b);
            for (int c = 0; c < DIV; c++) begin
                tests_run++;
                if (o_txd !== e || o_ready !== 1'b0 || o_busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s bit%0d cyc%0d: txd/ready/busy got %b%b%b want %b01",
                             name, b, c, o_txd, o_ready, o_busy, e);
                end
                @(negedge clk);
            end
        end
        tests_run++;
        if (o_txd !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s end_idle: txd/ready/busy got %b%b%b want 110",
                     name, o_txd, o_ready, o_busy);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_txd !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold: txd/ready/busy got %b%b%b want 110", o_txd, o_ready, o_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        // Start a frame and abort it partway through the data bits.
        i_data  = 8'h55;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (9) @(negedge clk);
        tests_run++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midframe_busy: busy/ready got %b%b want 10", o_busy, o_ready);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (o_txd !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: txd/ready/busy got %b%b%b want 110", o_txd, o_ready, o_busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (o_txd !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_quiet cyc%0d: txd/ready/busy got %b%b%b want 110",
                         i, o_txd, o_ready, o_busy);
            end
        end
    endtask

    task automatic test_single();
        run_frame("single_a5", 8'hA5, 8'hA5, 1'b0);
        @(negedge clk);
        tests_run++;
        if (o_txd !== 1'b1 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_a5 stays_idle: txd/ready got %b%b want 11", o_txd, o_ready);
        end
    endtask

    task automatic test_back_to_back();
        // i_valid stays high; the second start bit must follow one idle cycle.
        run_frame("b2b_00", 8'h00, 8'hFF, 1'b1);
        run_frame("b2b_ff", 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_data_hold();
        run_frame("hold_81", 8'h81, 8'h3C, 1'b0);
        @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        run_frame("parity_07", 8'h07, 8'h00, 1'b0);
        @(negedge clk);
        run_frame("parity_03", 8'h03, 8'h00, 1'b0);
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] d;
        for (int n = 0; n < 16; n++) begin
            d = DW'($urandom_range(0, 255));
            run_frame($sformatf("rand%0d", n), d, DW'($urandom_range(0, 255)), 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_data_hold();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
